// File: rtl/im_pkg.sv
// Shared types and helpers for the instruction prefetch path.
package im_pkg;

  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  // Out of range or misaligned; the limit is computed in 33 bits so a high base cannot wrap.
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input int unsigned depth);
    logic [32:0] lim;
    lim = {1'b0, base} + (33'(depth) << 2);
    return (pc < base) || ({1'b0, pc} >= lim) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/im_prefetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_fifo
  import im_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  fetch_entry_t                  din,
  input  logic                          pop,
  input  logic                          flush,
  output fetch_entry_t                  dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  fetch_entry_t    r_buf [FIFO_DEPTH];
  logic [PW:0]     r_wr, r_rd;
  logic            w_do_pop, w_do_push;

  assign count     = r_wr - r_rd;
  assign empty     = (r_wr == r_rd);
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_buf[r_rd[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_buf[r_wr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/im_prefetch.sv
// Instruction fetch memory: synchronous-read array, one read stage and a prefetch FIFO.
module im_prefetch
  import im_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          FIFO_DEPTH  = 4,
  parameter string       INIT_FILE   = "code.txt"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH);

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]  r_fetch_pc;
  logic         r_halted;
  logic         r_stg_vld;
  logic [31:0]  r_stg_pc;
  logic         r_stg_fault;
  logic [31:0]  r_rd_data;

  fetch_entry_t w_head, w_push_entry;
  logic [CW:0]  w_count;
  logic         w_full, w_empty;
  logic         w_pop, w_push, w_issue, w_fault;
  logic [CW+1:0] w_occ;

  assign w_pop   = !w_empty && out_ready;
  assign w_push  = r_stg_vld && !redirect;
  // Occupancy after this cycle's pop, counting the read already in the stage.
  assign w_occ   = {1'b0, w_count} + (CW+2)'(r_stg_vld) - (CW+2)'(w_pop);
  assign w_issue = !r_halted && !redirect && (w_occ < (CW+2)'(FIFO_DEPTH));
  assign w_fault = fetch_fault(r_fetch_pc, BASE_ADDR, DEPTH_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= BASE_ADDR;
      r_halted    <= 1'b0;
      r_stg_vld   <= 1'b0;
      r_stg_pc    <= '0;
      r_stg_fault <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc  <= redirect_pc;
      r_halted    <= 1'b0;
      r_stg_vld   <= 1'b0;
    end else begin
      r_stg_vld <= w_issue;
      if (w_issue) begin
        r_stg_pc    <= r_fetch_pc;
        r_stg_fault <= w_fault;
        r_fetch_pc  <= r_fetch_pc + 32'd4;
        if (w_fault) r_halted <= 1'b1;
      end
    end
  end

  // Out-of-range reads return garbage here; the fault flag masks it at push.
  always_ff @(posedge clk) begin
    if (w_issue) r_rd_data <= r_mem[AW'((r_fetch_pc - BASE_ADDR) >> 2)];
  end

  assign w_push_entry.pc    = r_stg_pc;
  assign w_push_entry.instr = r_stg_fault ? NOP_INSTR : r_rd_data;
  assign w_push_entry.fault = r_stg_fault;

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_push_entry),
    .pop   (w_pop && !redirect),
    .flush (redirect),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_instr = w_empty ? 32'h0 : w_head.instr;
  assign out_pc    = w_empty ? 32'h0 : w_head.pc;
  assign out_fault = w_empty ? 1'b0  : w_head.fault;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !(w_pop && !redirect)));

endmodule

// File: tb/tb_im_prefetch.sv
// Scoreboard bench for im_prefetch: expected entry streams are queued on reset/redirect.
module tb_im_prefetch;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 16;
  localparam int          FD    = 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        redirect = 0;
  logic [31:0] redirect_pc = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  always #5 clk = ~clk;

  im_prefetch #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } exp_t;

  logic [31:0] img [DEPTH];
  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order listing from a start PC: sequential words until the first bad address.
  task automatic model_start(input logic [31:0] pc);
    logic [31:0] p;
    exp_t e;
    exp_q.delete();
    p = pc;
    for (int n = 0; n < DEPTH + 2; n++) begin
      e.pc    = p;
      e.fault = (p < BASE) || (p >= BASE + 4 * DEPTH) || (p % 4 != 0);
      e.instr = e.fault ? 32'h0 : img[(p - BASE) / 4];
      exp_q.push_back(e);
      if (e.fault) break;
      p = p + 4;
    end
  endtask

  // Monitor: compares each accepted head entry and checks hold/idle behaviour.
  logic        hold_chk = 0;
  logic [31:0] prev_pc, prev_instr;
  logic        prev_fault;
  always @(negedge clk) begin
    if (rst_n && !redirect) begin
      if (out_valid) begin
        if (hold_chk) begin
          chk("hold_pc", out_pc, prev_pc);
          chk("hold_instr", out_instr, prev_instr);
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
        end else if (out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pc", out_pc, e.pc);
          chk("instr", out_instr, e.instr);
          chk("fault", {31'b0, out_fault}, {31'b0, e.fault});
        end
      end else begin
        chk("idle_zero", {out_instr ^ out_pc, 31'b0} | {32'b0, out_fault}, 64'd0);
      end
      hold_chk   = out_valid && !out_ready;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      prev_fault = out_fault;
    end else begin
      hold_chk = 0;
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_instr"}, out_instr, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_fault"}, {31'b0, out_fault}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 0;
    #1 chk_zero_outputs("async_rst");
    model_start(BASE);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    chk("rst_lat1", {31'b0, out_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_lat2", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic ready, input logic lat);
    @(posedge clk); #1;
    redirect = 1; redirect_pc = pc; out_ready = ready;
    @(posedge clk);
    model_start(pc);
    #1 redirect = 0;
    if (lat) begin
      @(negedge clk);
      chk("redir_valid0", {31'b0, out_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("redir_valid1", {31'b0, out_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("redir_valid2", {31'b0, out_valid}, 32'd1);
      chk("redir_pc", out_pc, pc);
    end
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 4 * $urandom_range(0, DEPTH - 1);
      3:       return BASE + $urandom_range(0, 4 * DEPTH - 1);
      4:       return BASE - 4 * $urandom_range(1, 4);
      default: return BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = (i < 8) ? 32'h1000_0000 + i : $urandom;
      dut.r_mem[i] = img[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");

    // Reset release, streaming through to the end of the array.
    model_start(BASE);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); @(negedge clk);
    chk("start_lat1", {31'b0, out_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("start_lat2", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("throughput", {31'b0, out_valid}, 32'd1);
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("end_drain", exp_q.size(), 32'd0);
    chk("halted_idle", {31'b0, out_valid}, 32'd0);

    // Backpressure from reset: buffer fills, issue stops.
    out_ready = 0;
    pulse_reset();
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_fetch_pc", dut.r_fetch_pc, BASE + 4 * FD);
    @(posedge clk); #1 out_ready = 1;
    repeat (6) @(posedge clk);

    // Redirect while the buffer is full and a handshake is active.
    do_redirect(BASE, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    do_redirect(BASE + 32'h20, 1'b1, 1'b1);
    repeat (12) @(posedge clk);
    chk("mid_drain", exp_q.size(), 32'd0);

    // Bad redirect targets each yield a single fault entry.
    do_redirect(BASE + 32'h2, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    chk("misalign_drain", exp_q.size(), 32'd0);
    do_redirect(BASE - 32'h4, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    chk("below_drain", exp_q.size(), 32'd0);
    do_redirect(BASE + 4 * DEPTH, 1'b1, 1'b1);
    repeat (5) @(posedge clk);

    // Mid-stream reset pulse.
    do_redirect(BASE + 32'h10, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    pulse_reset();
    repeat (4) @(posedge clk);

    // Random ready and redirects.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (redirect) model_start(redirect_pc);
      #1;
      redirect  = 0;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect    = 1;
        redirect_pc = pick_pc();
      end
    end
    @(posedge clk);
    if (redirect) model_start(redirect_pc);
    #1 redirect = 0; out_ready = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("final_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
